// File: rtl/div_seq_param_if.sv
`default_nettype none
// =============================================================================
// div_seq_param_if : control-unit <-> divider handshake and operand/result bus
// Revision: 1.0
// =============================================================================
interface div_seq_param_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             divControl;
  logic             signedMode;
  logic             divBusy;
  logic             divStop;
  logic             divZero;
  logic             divOverflow;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output a, b, divControl, signedMode,
    input  divBusy, divStop, divZero, divOverflow, hi, lo
  );

  modport slave (
    input  a, b, divControl, signedMode,
    output divBusy, divStop, divZero, divOverflow, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/div_seq_param.sv
`default_nettype none
// =============================================================================
// div_seq_param : multi-cycle restoring divider, runtime signed/unsigned mode
// Revision: 1.0
// =============================================================================
module div_seq_param #(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  wire logic      clk,
  input  wire logic      reset,
  div_seq_param_if.slave bus
);
  localparam int N  = WIDTH / STEPS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    C_CNT_LAST = CW'(N - 1);
  localparam logic [WIDTH-1:0] C_MIN      = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  // dq_q holds the dividend magnitude; quotient bits shift in as dividend bits shift out
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             qneg_q, rneg_q, ovf_pend_q, ovf_q, zero_q;

  logic             a_neg, b_neg, b_zero, start;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   sh;
  logic             qbit;

  always_comb begin
    a_neg  = bus.signedMode & bus.a[WIDTH-1];
    b_neg  = bus.signedMode & bus.b[WIDTH-1];
    a_abs  = a_neg ? -bus.a : bus.a;
    b_abs  = b_neg ? -bus.b : bus.b;
    b_zero = (bus.b == '0);
    start  = (state_q == S_IDLE) && bus.divControl;
  end

  always_comb begin
    rem_d = rem_q;
    dq_d  = dq_q;
    sh    = '0;
    qbit  = 1'b0;
    for (int s = 0; s < STEPS; s++) begin
      sh = {rem_d, dq_d[WIDTH-1]};
      if (sh >= {1'b0, dvs_q}) begin
        sh   = sh - {1'b0, dvs_q};
        qbit = 1'b1;
      end else begin
        qbit = 1'b0;
      end
      rem_d = sh[WIDTH-1:0];
      dq_d  = {dq_d[WIDTH-2:0], qbit};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Divide-by-zero passes through FIX (with results suppressed) so divStop lands one edge later
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.divControl) state_d = b_zero ? S_FIX : S_RUN;
      S_RUN:   if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.divBusy = (state_q == S_RUN) || ((state_q == S_FIX) && !zero_q);
    bus.divStop = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      dq_q       <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      if (start) begin
        dq_q       <= a_abs;
        dvs_q      <= b_abs;
        rem_q      <= '0;
        cnt_q      <= C_CNT_LAST;
        qneg_q     <= a_neg ^ b_neg;
        rneg_q     <= a_neg;
        ovf_pend_q <= bus.signedMode & (bus.a == C_MIN) & (&bus.b);
        ovf_q      <= 1'b0;
        zero_q     <= b_zero;
        hi_q       <= '0;
        lo_q       <= '0;
      end else if (state_q == S_RUN) begin
        rem_q <= rem_d;
        dq_q  <= dq_d;
        cnt_q <= cnt_q - CW'(1);
      end else if ((state_q == S_FIX) && !zero_q) begin
        lo_q  <= qneg_q ? -dq_q : dq_q;
        hi_q  <= rneg_q ? -rem_q : rem_q;
        ovf_q <= ovf_pend_q;
      end
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.divZero     = zero_q;
  assign bus.divOverflow = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_div_seq_param.sv
`default_nettype none
// =============================================================================
// tb_div_seq_param : directed self-checking bench for div_seq_param
// Revision: 1.0
// =============================================================================
module tb_div_seq_param;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  div_seq_param_if #(.WIDTH(32)) if_a ();
  div_seq_param_if #(.WIDTH(32)) if_b ();
  div_seq_param_if #(.WIDTH(8))  if_c ();

  div_seq_param #(.WIDTH(32), .STEPS(1)) dut_a (.clk(clk), .reset(rst_n), .bus(if_a));
  div_seq_param #(.WIDTH(32), .STEPS(2)) dut_b (.clk(clk), .reset(rst_n), .bus(if_b));
  div_seq_param #(.WIDTH(8),  .STEPS(2)) dut_c (.clk(clk), .reset(rst_n), .bus(if_c));

  int errors = 0;
  int checks = 0;

  logic [31:0] r_lo, r_hi;
  logic        r_z, r_ov, r_z0;
  int          r_lat, r_busycnt;

  function automatic logic get_stop(input int d);
    case (d)
      0:       return if_a.divStop;
      1:       return if_b.divStop;
      default: return if_c.divStop;
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0:       return if_a.divBusy;
      1:       return if_b.divBusy;
      default: return if_c.divBusy;
    endcase
  endfunction

  function automatic logic get_zero(input int d);
    case (d)
      0:       return if_a.divZero;
      1:       return if_b.divZero;
      default: return if_c.divZero;
    endcase
  endfunction

  function automatic logic get_ovf(input int d);
    case (d)
      0:       return if_a.divOverflow;
      1:       return if_b.divOverflow;
      default: return if_c.divOverflow;
    endcase
  endfunction

  function automatic logic [31:0] get_lo(input int d);
    case (d)
      0:       return if_a.lo;
      1:       return if_b.lo;
      default: return {24'h0, if_c.lo};
    endcase
  endfunction

  function automatic logic [31:0] get_hi(input int d);
    case (d)
      0:       return if_a.hi;
      1:       return if_b.hi;
      default: return {24'h0, if_c.hi};
    endcase
  endfunction

  task automatic drive(input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic sm, input logic go);
    case (d)
      0: begin if_a.a = a; if_a.b = b; if_a.signedMode = sm; if_a.divControl = go; end
      1: begin if_b.a = a; if_b.b = b; if_b.signedMode = sm; if_b.divControl = go; end
      default: begin
        if_c.a = a[7:0]; if_c.b = b[7:0]; if_c.signedMode = sm; if_c.divControl = go;
      end
    endcase
  endtask

  // Waits for divStop, counting edges after the start edge (r_lat) and busy-high samples
  task automatic wait_stop(input int d);
    r_busycnt = 0;
    forever begin
      if (get_busy(d)) r_busycnt++;
      if (get_stop(d) || r_lat >= 200) break;
      @(posedge clk); #1;
      r_lat++;
    end
    r_lo = get_lo(d);
    r_hi = get_hi(d);
    r_z  = get_zero(d);
    r_ov = get_ovf(d);
  endtask

  task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b, input logic sm);
    @(posedge clk); #1;
    drive(d, a, b, sm, 1'b1);
    @(posedge clk); #1;
    drive(d, a, b, sm, 1'b0);
    r_z0  = get_zero(d);
    r_lat = 0;
    wait_stop(d);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(2, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({if_a.lo, if_a.hi} !== 64'h0) begin
      errors++; $display("FAIL reset_lohi got=%h exp=0", {if_a.lo, if_a.hi});
    end
    checks++;
    if ({if_a.divBusy, if_a.divStop, if_a.divZero, if_a.divOverflow} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000",
                         {if_a.divBusy, if_a.divStop, if_a.divZero, if_a.divOverflow});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    run_op(0, 32'd7, 32'd2, 1'b1);
    checks++;
    if (r_lo !== 32'd3 || r_hi !== 32'd1) begin
      errors++; $display("FAIL basic_7_2 got lo=%h hi=%h exp lo=3 hi=1", r_lo, r_hi);
    end
    checks++;
    if (r_lat !== 33) begin errors++; $display("FAIL basic_latency got=%0d exp=33", r_lat); end
    checks++;
    if (r_busycnt !== 33) begin
      errors++; $display("FAIL basic_busy_cycles got=%0d exp=33", r_busycnt);
    end
    checks++;
    if ({r_z, r_ov} !== 2'b00) begin errors++; $display("FAIL basic_flags got=%b exp=00", {r_z, r_ov}); end
    @(posedge clk); #1;
    checks++;
    if (if_a.divStop !== 1'b0) begin errors++; $display("FAIL basic_stop_pulse got=1 exp=0"); end
  endtask

  task automatic test_signs;
    run_op(0, 32'hFFFF_FFF9, 32'd2, 1'b1);
    checks++;
    if (r_lo !== 32'hFFFF_FFFD || r_hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL sign_m7_2 got lo=%h hi=%h exp lo=fffffffd hi=ffffffff", r_lo, r_hi);
    end
    run_op(0, 32'd7, 32'hFFFF_FFFE, 1'b1);
    checks++;
    if (r_lo !== 32'hFFFF_FFFD || r_hi !== 32'd1) begin
      errors++; $display("FAIL sign_7_m2 got lo=%h hi=%h exp lo=fffffffd hi=1", r_lo, r_hi);
    end
    run_op(0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    checks++;
    if (r_lo !== 32'h7FFF_FFFF || r_hi !== 32'd1) begin
      errors++; $display("FAIL unsigned_max_2 got lo=%h hi=%h exp lo=7fffffff hi=1", r_lo, r_hi);
    end
    run_op(0, 32'hFFFF_FFFF, 32'd2, 1'b1);
    checks++;
    if (r_lo !== 32'd0 || r_hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL signed_m1_2 got lo=%h hi=%h exp lo=0 hi=ffffffff", r_lo, r_hi);
    end
  endtask

  task automatic test_corner;
    run_op(0, 32'd123, 32'd0, 1'b1);
    checks++;
    if ({r_z, r_ov} !== 2'b10 || r_lo !== 32'd0 || r_hi !== 32'd0) begin
      errors++; $display("FAIL divzero got z=%b ov=%b lo=%h hi=%h exp z=1 ov=0 lo=0 hi=0",
                         r_z, r_ov, r_lo, r_hi);
    end
    checks++;
    if (r_lat !== 1 || r_busycnt !== 0) begin
      errors++; $display("FAIL divzero_timing got lat=%0d busy=%0d exp lat=1 busy=0", r_lat, r_busycnt);
    end
    run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    checks++;
    if (r_z0 !== 1'b0) begin errors++; $display("FAIL divzero_clear got=%b exp=0", r_z0); end
    checks++;
    if (r_lo !== 32'h8000_0000 || r_hi !== 32'd0 || r_ov !== 1'b1) begin
      errors++; $display("FAIL overflow got lo=%h hi=%h ov=%b exp lo=80000000 hi=0 ov=1",
                         r_lo, r_hi, r_ov);
    end
    run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (r_lo !== 32'd0 || r_hi !== 32'h8000_0000 || r_ov !== 1'b0) begin
      errors++; $display("FAIL unsigned_no_ovf got lo=%h hi=%h ov=%b exp lo=0 hi=80000000 ov=0",
                         r_lo, r_hi, r_ov);
    end
  endtask

  task automatic test_busy_ignore;
    int stops;
    @(posedge clk); #1;
    drive(0, 32'd100, 32'd7, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(0, 32'd100, 32'd7, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    drive(0, 32'd1, 32'd1, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(0, 32'd1, 32'd1, 1'b1, 1'b0);
    r_lat = 5;
    wait_stop(0);
    checks++;
    if (r_lo !== 32'd14 || r_hi !== 32'd2 || r_lat !== 33) begin
      errors++; $display("FAIL ignore_start got lo=%h hi=%h lat=%0d exp lo=e hi=2 lat=33",
                         r_lo, r_hi, r_lat);
    end
    @(posedge clk); #1;
    drive(0, 32'd100, 32'd7, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(0, 32'd100, 32'd7, 1'b1, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if_a.lo, if_a.hi} !== 64'h0 ||
        {if_a.divBusy, if_a.divStop, if_a.divZero, if_a.divOverflow} !== 4'b0000) begin
      errors++; $display("FAIL abort_outputs got lo=%h hi=%h busy=%b stop=%b exp all 0",
                         if_a.lo, if_a.hi, if_a.divBusy, if_a.divStop);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    stops = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (if_a.divStop) stops++;
    end
    checks++;
    if (stops !== 0) begin errors++; $display("FAIL abort_no_stop got=%0d exp=0", stops); end
  endtask

  task automatic test_back_to_back;
    int gap;
    @(posedge clk); #1;
    drive(0, 32'd20, 32'd6, 1'b0, 1'b1);
    r_lat = 0;
    wait_stop(0);
    gap = 0;
    do begin
      @(posedge clk); #1;
      gap++;
    end while (!if_a.divStop && gap < 200);
    drive(0, 32'd20, 32'd6, 1'b0, 1'b0);
    checks++;
    if (gap !== 35) begin errors++; $display("FAIL b2b_gap got=%0d exp=35", gap); end
    checks++;
    if (if_a.lo !== 32'd3 || if_a.hi !== 32'd2) begin
      errors++; $display("FAIL b2b_result got lo=%h hi=%h exp lo=3 hi=2", if_a.lo, if_a.hi);
    end
  endtask

  task automatic test_steps2;
    run_op(1, 32'd1000, 32'hFFFF_FFFD, 1'b1);
    checks++;
    if (r_lo !== 32'hFFFF_FEB3 || r_hi !== 32'd1 || r_lat !== 17) begin
      errors++; $display("FAIL s2_1000_m3 got lo=%h hi=%h lat=%0d exp lo=fffffeb3 hi=1 lat=17",
                         r_lo, r_hi, r_lat);
    end
    run_op(1, 32'hDEAD_BEEF, 32'h10, 1'b0);
    checks++;
    if (r_lo !== 32'h0DEA_DBEE || r_hi !== 32'hF) begin
      errors++; $display("FAIL s2_deadbeef got lo=%h hi=%h exp lo=0deadbee hi=f", r_lo, r_hi);
    end
    run_op(1, 32'hFFFF_FF9C, 32'd7, 1'b1);
    checks++;
    if (r_lo !== 32'hFFFF_FFF2 || r_hi !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL s2_m100_7 got lo=%h hi=%h exp lo=fffffff2 hi=fffffffe", r_lo, r_hi);
    end
    run_op(1, 32'd5, 32'd9, 1'b0);
    checks++;
    if (r_lo !== 32'd0 || r_hi !== 32'd5) begin
      errors++; $display("FAIL s2_5_9 got lo=%h hi=%h exp lo=0 hi=5", r_lo, r_hi);
    end
  endtask

  task automatic test_width8;
    run_op(2, 32'h80, 32'h03, 1'b1);
    checks++;
    if (r_lo !== 32'hD6 || r_hi !== 32'hFE || r_lat !== 5) begin
      errors++; $display("FAIL w8_m128_3 got lo=%h hi=%h lat=%0d exp lo=d6 hi=fe lat=5",
                         r_lo, r_hi, r_lat);
    end
    run_op(2, 32'h80, 32'h03, 1'b0);
    checks++;
    if (r_lo !== 32'h2A || r_hi !== 32'h02) begin
      errors++; $display("FAIL w8_u128_3 got lo=%h hi=%h exp lo=2a hi=2", r_lo, r_hi);
    end
    run_op(2, 32'h80, 32'hFF, 1'b1);
    checks++;
    if (r_lo !== 32'h80 || r_hi !== 32'h00 || r_ov !== 1'b1) begin
      errors++; $display("FAIL w8_ovf got lo=%h hi=%h ov=%b exp lo=80 hi=0 ov=1", r_lo, r_hi, r_ov);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_corner();
    test_busy_ignore();
    test_back_to_back();
    test_steps2();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
